// File: rtl/mult_op_driver.sv
// Operand feeder for the 16x16 signed parity-protected multiplier: queues operand
// pairs, runs the req/ack/result_rdy handshake and returns one result record per pair.
module mult_op_driver #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [15:0]            in_a,
  input  logic [15:0]            in_b,
  input  logic                   in_corrupt_a,
  input  logic                   in_corrupt_b,
  output logic [15:0]            arg_a,
  output logic                   arg_a_parity,
  output logic [15:0]            arg_b,
  output logic                   arg_b_parity,
  output logic                   req,
  input  logic                   ack,
  input  logic [31:0]            result,
  input  logic                   result_parity,
  input  logic                   result_rdy,
  input  logic                   arg_parity_error,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_result,
  output logic                   out_arg_err,
  output logic                   out_res_par_err,
  output logic                   out_timeout,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RDY, OUT} state_t;

  state_t        state, state_next;
  logic [33:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [TW-1:0] timer, timer_next;
  logic          push, pop, timeout_hit, do_capture, do_abort;
  logic [15:0]   arg_a_next, arg_b_next;
  logic          arg_a_parity_next, arg_b_parity_next, req_next;
  logic          out_valid_next, out_arg_err_next, out_res_par_err_next, out_timeout_next;
  logic [31:0]   out_result_next;

  assign in_ready   = (count != FULL_COUNT);
  assign push       = in_valid && in_ready;
  assign pop        = (state == IDLE) && (count != '0);
  assign busy       = (state != IDLE);
  assign fifo_count = count;

  // Parity travels with the operand so a corrupted pair stays corrupted until it is issued.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {in_a, (^in_a) ^ in_corrupt_a, in_b, (^in_b) ^ in_corrupt_b};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end

  always_comb begin
    state_next           = state;
    timer_next           = timer;
    req_next             = req;
    arg_a_next           = arg_a;
    arg_b_next           = arg_b;
    arg_a_parity_next    = arg_a_parity;
    arg_b_parity_next    = arg_b_parity;
    out_valid_next       = out_valid;
    out_result_next      = out_result;
    out_arg_err_next     = out_arg_err;
    out_res_par_err_next = out_res_par_err;
    out_timeout_next     = out_timeout;
    do_capture           = 1'b0;
    do_abort             = 1'b0;
    timeout_hit          = (timer == TIMER_LAST);

    case (state)
      IDLE: begin
        if (pop) begin
          {arg_a_next, arg_a_parity_next, arg_b_next, arg_b_parity_next} = mem[rd_ptr];
          req_next   = 1'b1;
          timer_next = '0;
          state_next = REQ;
        end
      end
      REQ: begin
        if (ack) begin
          req_next   = 1'b0;
          timer_next = '0;
          if (result_rdy) do_capture = 1'b1;
          else            state_next = WAIT_RDY;
        end else if (timeout_hit) begin
          do_abort = 1'b1;
        end else begin
          timer_next = timer + TW'(1);
        end
      end
      WAIT_RDY: begin
        if (result_rdy)       do_capture = 1'b1;
        else if (timeout_hit) do_abort = 1'b1;
        else                  timer_next = timer + TW'(1);
      end
      OUT: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
    endcase

    // A late ack wins over the timeout when both land on the same edge.
    if (do_capture) begin
      out_result_next      = result;
      out_arg_err_next     = arg_parity_error;
      out_res_par_err_next = result_parity ^ (^result);
      out_timeout_next     = 1'b0;
      out_valid_next       = 1'b1;
      state_next           = OUT;
    end
    if (do_abort) begin
      req_next             = 1'b0;
      out_result_next      = '0;
      out_arg_err_next     = 1'b0;
      out_res_par_err_next = 1'b0;
      out_timeout_next     = 1'b1;
      out_valid_next       = 1'b1;
      state_next           = OUT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      timer           <= '0;
      req             <= 1'b0;
      arg_a           <= '0;
      arg_b           <= '0;
      arg_a_parity    <= 1'b0;
      arg_b_parity    <= 1'b0;
      out_valid       <= 1'b0;
      out_result      <= '0;
      out_arg_err     <= 1'b0;
      out_res_par_err <= 1'b0;
      out_timeout     <= 1'b0;
    end else begin
      state           <= state_next;
      timer           <= timer_next;
      req             <= req_next;
      arg_a           <= arg_a_next;
      arg_b           <= arg_b_next;
      arg_a_parity    <= arg_a_parity_next;
      arg_b_parity    <= arg_b_parity_next;
      out_valid       <= out_valid_next;
      out_result      <= out_result_next;
      out_arg_err     <= out_arg_err_next;
      out_res_par_err <= out_res_par_err_next;
      out_timeout     <= out_timeout_next;
    end
  end
endmodule
